// File: rtl/fsm_seq_pkg.sv
// rtl/fsm_seq_pkg.sv - shared state encoding and parameter limits for the phase sequencer
package fsm_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_HOLD = 2'd2,
    ST_DONE = 2'd3
  } seq_state_e;

  localparam int NUM_PHASE_MIN = 2;
  localparam int NUM_PHASE_MAX = 16;
  localparam int CNT_W_MIN     = 1;
  localparam int CNT_W_MAX     = 16;

  function automatic logic is_active(seq_state_e s);
    return (s == ST_RUN) || (s == ST_HOLD);
  endfunction

endpackage

// File: rtl/fsm_seq_dwell_cnt.sv
// rtl/fsm_seq_dwell_cnt.sv - per-phase dwell counter with latched length and terminal count
module seq_dwell_cnt
  import fsm_seq_pkg::*;
#(
  parameter int CNT_W = 4
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             load,
  input  logic             clr,
  input  logic             en,
  input  logic [CNT_W-1:0] dwell,
  output logic             tc
);

  logic [CNT_W-1:0] dwell_q;
  logic [CNT_W-1:0] cnt;

  // A zero dwell is stored as one so every phase lasts at least a cycle.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      dwell_q <= CNT_W'(1);
      cnt     <= '0;
    end else if (load) begin
      dwell_q <= (dwell == '0) ? CNT_W'(1) : dwell;
      cnt     <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tc ? '0 : cnt + CNT_W'(1);
    end
  end

  assign tc = (cnt == dwell_q - CNT_W'(1));

endmodule

// File: rtl/fsm_seq.sv
// rtl/fsm_seq.sv - multi-phase run sequencer with hold, abort and optional looping
module fsm_seq
  import fsm_seq_pkg::*;
#(
  parameter int NUM_PHASE = 4,
  parameter int CNT_W     = 4,
  parameter int PH_W      = $clog2(NUM_PHASE)
) (
  input  logic             clk,
  input  logic             n_rst,
  input  logic             start,
  input  logic             hold,
  input  logic             abort,
  input  logic [CNT_W-1:0] dwell,
  input  logic             loop_en,
  output logic [PH_W-1:0]  state_out,
  output logic             busy,
  output logic             phase_strobe,
  output logic             done
);

  localparam logic [PH_W-1:0] LAST_PH = PH_W'(NUM_PHASE - 1);

  seq_state_e      state_q;
  seq_state_e      state_d;
  logic [PH_W-1:0] phase_d;
  logic            strobe_d;
  logic            busy_d;
  logic            done_d;
  logic            loop_q;
  logic            cnt_load;
  logic            cnt_clr;
  logic            cnt_en;
  logic            tc;

  seq_dwell_cnt #(
    .CNT_W(CNT_W)
  ) u_dwell_cnt (
    .clk  (clk),
    .n_rst(n_rst),
    .load (cnt_load),
    .clr  (cnt_clr),
    .en   (cnt_en),
    .dwell(dwell),
    .tc   (tc)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q      <= ST_IDLE;
      state_out    <= '0;
      busy         <= 1'b0;
      phase_strobe <= 1'b0;
      done         <= 1'b0;
      loop_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      state_out    <= phase_d;
      busy         <= busy_d;
      phase_strobe <= strobe_d;
      done         <= done_d;
      if (cnt_load) begin
        loop_q <= loop_en;
      end
    end
  end

  // A hold sampled on a phase boundary still takes the advance; the freeze starts after it.
  always_comb begin
    state_d  = state_q;
    phase_d  = state_out;
    strobe_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        phase_d = '0;
        if (start && !abort) begin
          state_d = ST_RUN;
        end
      end
      ST_RUN: begin
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else begin
          state_d = hold ? ST_HOLD : ST_RUN;
          if (tc) begin
            if (state_out != LAST_PH) begin
              phase_d  = state_out + PH_W'(1);
              strobe_d = 1'b1;
            end else if (loop_q) begin
              phase_d  = '0;
              strobe_d = 1'b1;
            end else begin
              state_d = ST_DONE;
            end
          end
        end
      end
      ST_HOLD: begin
        if (abort) begin
          state_d = ST_IDLE;
          phase_d = '0;
        end else if (!hold) begin
          state_d = ST_RUN;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
      default: begin
        state_d = ST_IDLE;
        phase_d = '0;
      end
    endcase
  end

  always_comb begin
    busy_d   = is_active(state_d);
    done_d   = (state_d == ST_DONE);
    cnt_load = (state_q == ST_IDLE) && start && !abort;
    cnt_clr  = abort && (state_q != ST_IDLE);
    cnt_en   = (state_q == ST_RUN);
  end

endmodule

// File: tb/tb_fsm_seq.sv
// tb/tb_fsm_seq.sv - directed self-checking bench for fsm_seq
module tb_fsm_seq;

  logic       clk = 1'b0;
  logic       n_rst;
  logic       start;
  logic       hold;
  logic       abort;
  logic [3:0] dwell;
  logic       loop_en;
  logic [1:0] state_out;
  logic       busy;
  logic       phase_strobe;
  logic       done;

  int checks = 0;
  int failures = 0;

  fsm_seq #(
    .NUM_PHASE(4),
    .CNT_W    (4),
    .PH_W     (2)
  ) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .start       (start),
    .hold        (hold),
    .abort       (abort),
    .dwell       (dwell),
    .loop_en     (loop_en),
    .state_out   (state_out),
    .busy        (busy),
    .phase_strobe(phase_strobe),
    .done        (done)
  );

  always #5 clk = ~clk;

  // Leaves the bench at the falling edge inside cycle 1 of the new run.
  task automatic launch(input logic [3:0] d, input logic l);
    dwell   = d;
    loop_en = l;
    start   = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic test_reset();
    logic [4:0] got;
    n_rst = 1'b0;
    start = 1'b1;
    #2;
    got = {busy, state_out, phase_strobe, done};
    checks++;
    if (got !== 5'b0) begin
      failures++;
      $display("FAIL reset_initial got=%b exp=%b", got, 5'b0);
    end
    @(negedge clk);
    @(negedge clk);
    got = {busy, state_out, phase_strobe, done};
    checks++;
    if (got !== 5'b0) begin
      failures++;
      $display("FAIL reset_start_ignored got=%b exp=%b", got, 5'b0);
    end
    start = 1'b0;
    n_rst = 1'b1;
    @(negedge clk);
    got = {busy, state_out, phase_strobe, done};
    checks++;
    if (got !== 5'b0) begin
      failures++;
      $display("FAIL reset_idle_after_release got=%b exp=%b", got, 5'b0);
    end
  endtask

  task automatic test_basic();
    logic [4:0] exp, got;
    int ph;
    launch(4'd4, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      ph  = (c <= 16) ? (c - 1) / 4 : ((c == 17) ? 3 : 0);
      exp = {(c <= 16), 2'(ph), (c == 5 || c == 9 || c == 13), (c == 17)};
      got = {busy, state_out, phase_strobe, done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL basic c=%0d got=%b exp=%b", c, got, exp);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_start_while_busy();
    logic [4:0] exp, got;
    int ph;
    launch(4'd4, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      ph  = (c <= 16) ? (c - 1) / 4 : ((c == 17) ? 3 : 0);
      exp = {(c <= 16), 2'(ph), (c == 5 || c == 9 || c == 13), (c == 17)};
      got = {busy, state_out, phase_strobe, done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL start_busy c=%0d got=%b exp=%b", c, got, exp);
      end
      start   = (c == 3 || c == 9);
      dwell   = (c >= 3) ? 4'd1 : 4'd4;
      loop_en = (c >= 3);
      @(negedge clk);
    end
    start   = 1'b0;
    loop_en = 1'b0;
  endtask

  task automatic test_loop();
    logic [4:0] exp, got;
    launch(4'd2, 1'b1);
    for (int c = 1; c <= 24; c++) begin
      if (c <= 22)
        exp = {1'b1, 2'(((c - 1) / 2) % 4), (c >= 3 && (c - 1) % 2 == 0), 1'b0};
      else
        exp = 5'b0;
      got = {busy, state_out, phase_strobe, done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL loop c=%0d got=%b exp=%b", c, got, exp);
      end
      if (c == 4) begin
        dwell   = 4'd7;
        loop_en = 1'b0;
      end
      abort = (c == 22);
      @(negedge clk);
    end
    abort = 1'b0;
  endtask

  task automatic test_hold();
    logic [4:0] exp, got;
    int e, ph;
    launch(4'd4, 1'b0);
    for (int c = 1; c <= 22; c++) begin
      e   = (c <= 7) ? c : ((c <= 10) ? 7 : c - 3);
      ph  = (e <= 16) ? (e - 1) / 4 : ((e == 17) ? 3 : 0);
      exp = {(e <= 16), 2'(ph), (e == 5 || e == 9 || e == 13), (e == 17)};
      got = {busy, state_out, phase_strobe, done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL hold c=%0d got=%b exp=%b", c, got, exp);
      end
      hold = (c >= 6 && c <= 8);
      @(negedge clk);
    end
    hold = 1'b0;
  endtask

  task automatic test_hold_boundary();
    logic [4:0] exp, got;
    int e, ph;
    launch(4'd2, 1'b0);
    for (int c = 1; c <= 12; c++) begin
      e   = (c <= 3) ? c : c - 1;
      ph  = (e <= 8) ? (e - 1) / 2 : ((e == 9) ? 3 : 0);
      exp = {(e <= 8), 2'(ph), ((e == 3 || e == 5 || e == 7) && c != 4), (e == 9)};
      got = {busy, state_out, phase_strobe, done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL hold_boundary c=%0d got=%b exp=%b", c, got, exp);
      end
      hold = (c == 2);
      @(negedge clk);
    end
    hold = 1'b0;
  endtask

  task automatic test_abort();
    logic [4:0] exp, got;
    int ph;
    launch(4'd4, 1'b0);
    for (int c = 1; c <= 18; c++) begin
      ph  = (c - 1) / 4;
      exp = (c <= 12) ? {1'b1, 2'(ph), (c == 5 || c == 9), 1'b0} : 5'b0;
      got = {busy, state_out, phase_strobe, done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL abort c=%0d got=%b exp=%b", c, got, exp);
      end
      abort = (c == 12);
      @(negedge clk);
    end
    abort = 1'b0;
    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      got = {busy, state_out, phase_strobe, done};
      checks++;
      if (got !== 5'b0) begin
        failures++;
        $display("FAIL start_abort_idle c=%0d got=%b exp=%b", c, got, 5'b0);
      end
      @(negedge clk);
    end
  endtask

  task automatic test_async_reset();
    logic [4:0] exp, got;
    launch(4'd4, 1'b0);
    for (int c = 1; c < 6; c++) @(negedge clk);
    #2;
    n_rst = 1'b0;
    #1;
    got = {busy, state_out, phase_strobe, done};
    checks++;
    if (got !== 5'b0) begin
      failures++;
      $display("FAIL async_reset_midcycle got=%b exp=%b", got, 5'b0);
    end
    start = 1'b1;
    @(negedge clk);
    got = {busy, state_out, phase_strobe, done};
    checks++;
    if (got !== 5'b0) begin
      failures++;
      $display("FAIL async_reset_held got=%b exp=%b", got, 5'b0);
    end
    n_rst = 1'b1;
    @(negedge clk);
    start = 1'b0;
    exp = {1'b1, 2'd0, 1'b0, 1'b0};
    got = {busy, state_out, phase_strobe, done};
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL launch_after_release got=%b exp=%b", got, exp);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    got = {busy, state_out, phase_strobe, done};
    checks++;
    if (got !== 5'b0) begin
      failures++;
      $display("FAIL abort_after_release got=%b exp=%b", got, 5'b0);
    end
  endtask

  task automatic test_dwell_zero();
    logic [4:0] exp, got;
    int ph;
    launch(4'd0, 1'b0);
    for (int c = 1; c <= 6; c++) begin
      ph  = (c <= 4) ? c - 1 : ((c == 5) ? 3 : 0);
      exp = {(c <= 4), 2'(ph), (c >= 2 && c <= 4), (c == 5)};
      got = {busy, state_out, phase_strobe, done};
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL dwell_zero c=%0d got=%b exp=%b", c, got, exp);
      end
      @(negedge clk);
    end
  endtask

  initial begin
    n_rst   = 1'b0;
    start   = 1'b0;
    hold    = 1'b0;
    abort   = 1'b0;
    dwell   = 4'd0;
    loop_en = 1'b0;
    test_reset();
    test_basic();
    test_start_while_busy();
    test_loop();
    test_hold();
    test_hold_boundary();
    test_abort();
    test_async_reset();
    test_dwell_zero();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
